// File: rtl/tetris_round_ctrl.sv
// tetris_round_ctrl: issues host pieces one at a time to a Tetris core and collects per-round results.
module tetris_round_ctrl #(
    parameter int PIECES_PER_ROUND = 16,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_tetromino,
    input  logic [2:0]  req_position,
    output logic        req_ready,
    output logic        core_in_valid,
    output logic [2:0]  core_tetrominoes,
    output logic [2:0]  core_position,
    input  logic        core_score_valid,
    input  logic        core_fail,
    input  logic [3:0]  core_score,
    input  logic        core_tetris_valid,
    input  logic [71:0] core_tetris,
    output logic        round_done,
    output logic        round_fail,
    output logic [3:0]  round_score,
    output logic [4:0]  round_pieces,
    output logic [71:0] round_board,
    output logic        err,
    input  logic        err_clr
);
    typedef enum logic [1:0] {ISSUE, WAIT, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [4:0] count;
    logic [5:0] timer;
    logic hs, finish;
    always_comb begin
        state_nx = state;
        hs = 1'b0;
        finish = 1'b0;
        case (state)
            ISSUE: begin
                hs = req_valid;
                state_nx = req_valid ? WAIT : ISSUE;
            end
            WAIT: begin
                finish = core_score_valid && (core_fail || count == 5'(PIECES_PER_ROUND));
                state_nx = core_score_valid ? (finish ? DONE : ISSUE)
                         : (timer == 6'(TIMEOUT - 1) ? ERR : WAIT);
            end
            DONE: state_nx = ISSUE;
            ERR: state_nx = err_clr ? ISSUE : ERR;
            default: state_nx = ISSUE;
        endcase
    end
    assign req_ready = state == ISSUE;
    assign round_done = state == DONE;
    assign err = state == ERR;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ISSUE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_in_valid <= 1'b0;
            core_tetrominoes <= '0;
            core_position <= '0;
            count <= '0;
            timer <= '0;
            round_fail <= 1'b0;
            round_score <= '0;
            round_pieces <= '0;
            round_board <= '0;
        end else begin
            core_in_valid <= hs;
            core_tetrominoes <= hs ? req_tetromino : '0;
            core_position <= hs ? req_position : '0;
            if (hs) count <= count + 5'd1;
            else if (state == DONE || (state == ERR && err_clr)) count <= '0;
            if (hs) timer <= '0;
            else if (state == WAIT && !core_score_valid) timer <= timer + 6'd1;
            if (finish) begin
                round_fail <= core_fail;
                round_score <= core_score;
                round_pieces <= count;
                round_board <= core_tetris_valid ? core_tetris : '0;
            end
        end
    end
endmodule

// File: tb/tb_tetris_round_ctrl.sv
// tb_tetris_round_ctrl: directed checks of round completion, failure, timeout, reset and back-to-back issue.
module tb_tetris_round_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_tetromino = '0;
    logic [2:0]  req_position = '0;
    logic        req_ready;
    logic        core_in_valid;
    logic [2:0]  core_tetrominoes;
    logic [2:0]  core_position;
    logic        core_score_valid = 1'b0;
    logic        core_fail = 1'b0;
    logic [3:0]  core_score = '0;
    logic        core_tetris_valid = 1'b0;
    logic [71:0] core_tetris = '0;
    logic        round_done;
    logic        round_fail;
    logic [3:0]  round_score;
    logic [4:0]  round_pieces;
    logic [71:0] round_board;
    logic        err;
    logic        err_clr = 1'b0;

    localparam logic [71:0] BOARD_A = 72'h123456789abcdef012;
    localparam logic [71:0] BOARD_B = 72'hfedcba9876543210aa;

    int compared = 0;
    int mismatched = 0;

    tetris_round_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_tetromino(req_tetromino), .req_position(req_position),
        .req_ready(req_ready),
        .core_in_valid(core_in_valid), .core_tetrominoes(core_tetrominoes), .core_position(core_position),
        .core_score_valid(core_score_valid), .core_fail(core_fail), .core_score(core_score),
        .core_tetris_valid(core_tetris_valid), .core_tetris(core_tetris),
        .round_done(round_done), .round_fail(round_fail), .round_score(round_score),
        .round_pieces(round_pieces), .round_board(round_board),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_core_tet", core_tetrominoes, 0);
        chk("rst_core_pos", core_position, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_round_fail", round_fail, 0);
        chk("rst_round_score", round_score, 0);
        chk("rst_round_pieces", round_pieces, 0);
        chk("rst_round_board", round_board, 0);
        chk("rst_err", err, 0);
    endtask

    // Called at a falling edge with the controller in ISSUE; returns one cycle after the handshake.
    task automatic issue(input logic [2:0] t, input logic [2:0] p);
        chk("issue_ready", req_ready, 1);
        req_valid = 1'b1;
        req_tetromino = t;
        req_position = p;
        @(negedge clk);
        req_valid = 1'b0;
        chk("core_in_valid", core_in_valid, 1);
        chk("core_tet", core_tetrominoes, t);
        chk("core_pos", core_position, p);
        chk("wait_ready", req_ready, 0);
    endtask

    task automatic answer(input int lat, input logic f, input logic [3:0] s, input logic tv,
                          input logic [71:0] b, input logic done);
        repeat (lat) begin
            @(negedge clk);
            chk("civ_idle", core_in_valid, 0);
            chk("tet_idle", core_tetrominoes, 0);
        end
        core_score_valid = 1'b1;
        core_fail = f;
        core_score = s;
        core_tetris_valid = tv;
        core_tetris = b;
        @(negedge clk);
        core_score_valid = 1'b0;
        core_fail = 1'b0;
        core_tetris_valid = 1'b0;
        core_tetris = '0;
        chk("round_done", round_done, done);
    endtask

    task automatic chk_round(input logic f, input logic [3:0] s, input logic [4:0] n, input logic [71:0] b);
        chk("round_fail", round_fail, f);
        chk("round_score", round_score, s);
        chk("round_pieces", round_pieces, n);
        chk("round_board", round_board, b);
        @(negedge clk);
        chk("done_one_cycle", round_done, 0);
        chk("ready_after_done", req_ready, 1);
    endtask

    initial begin
        int civ_cnt;
        int ans_cnt;
        logic last_civ;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;

        // Full round of 16 pieces, no failure, board valid on the last answer.
        for (int i = 1; i <= 16; i++) begin
            issue(3'(i), 3'(~i));
            answer(3, 1'b0, (i == 16) ? 4'd2 : 4'(i), i == 16, BOARD_A, i == 16);
        end
        chk_round(1'b0, 4'd2, 5'd16, BOARD_A);

        // A score strobe outside WAIT must be ignored, as must err_clr.
        core_score_valid = 1'b1;
        core_fail = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        core_score_valid = 1'b0;
        core_fail = 1'b0;
        err_clr = 1'b0;
        chk("stray_csv_ready", req_ready, 1);
        @(negedge clk);
        chk("stray_csv_done", round_done, 0);

        // Failure on piece 5 with an invalid board.
        for (int i = 1; i <= 5; i++) begin
            issue(3'(i + 2), 3'(i));
            answer(2, i == 5, 4'd7, 1'b0, BOARD_B, i == 5);
        end
        chk_round(1'b1, 4'd7, 5'd5, 72'd0);

        // Next round starts at count 1; fail and count limit together on piece 16.
        for (int i = 1; i <= 16; i++) begin
            issue(3'(i), 3'(i + 1));
            answer(1, i == 16, 4'd9, i == 16, BOARD_B, i == 16);
        end
        chk_round(1'b1, 4'd9, 5'd16, BOARD_B);

        // Reset while waiting on piece 9.
        for (int i = 1; i <= 8; i++) begin
            issue(3'(i), 3'(i));
            answer(1, 1'b0, 4'd1, 1'b0, BOARD_A, 1'b0);
        end
        issue(3'd5, 3'd6);
        @(negedge clk);
        chk("mid_wait_ready", req_ready, 0);
        #2 rst = 1'b1;
        #1 chk_reset_state();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            issue(3'(i), 3'(i));
            answer(1, i == 3, 4'd4, 1'b0, BOARD_A, i == 3);
        end
        chk_round(1'b1, 4'd4, 5'd3, 72'd0);

        // Continuous requests with a one-cycle core: never more than one piece outstanding.
        civ_cnt = 0;
        ans_cnt = 0;
        last_civ = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            core_score_valid = last_civ;
            last_civ = core_in_valid;
            if (core_in_valid) civ_cnt++;
            if (core_score_valid) ans_cnt++;
            chk("outstanding", (civ_cnt - ans_cnt) <= 1, 1);
        end
        req_valid = 1'b0;
        core_score_valid = 1'b0;
        chk("b2b_issued", civ_cnt, 10);
        chk("b2b_answered", ans_cnt, 10);

        // Core never answers.
        issue(3'd1, 3'd2);
        repeat (62) @(negedge clk);
        chk("pre_timeout_err", err, 0);
        @(negedge clk);
        chk("timeout_err", err, 1);
        chk("timeout_ready", req_ready, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", err, 0);
        chk("err_clr_ready", req_ready, 1);
        issue(3'd6, 3'd3);
        answer(1, 1'b1, 4'd3, 1'b1, BOARD_A, 1'b1);
        chk_round(1'b1, 4'd3, 5'd1, BOARD_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/tetris_round_ctrl.md
TETRIS_ROUND_CTRL -- requirements
Module: tetris_round_ctrl

Interface
REQ-001 Parameter PIECES_PER_ROUND, default 16, SHALL set the maximum pieces issued per round.
REQ-002 Parameter TIMEOUT, default 63, SHALL set the maximum cycles to wait for core_score_valid after an issue.
REQ-003 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  host offers a piece.
REQ-006 req_tetromino  in  3  piece shape.
REQ-007 req_position  in  3  piece column.
REQ-008 req_ready  out  1  controller accepts a piece this cycle.
REQ-009 core_in_valid  out  1  one-cycle piece strobe to the game core.
REQ-010 core_tetrominoes  out  3  piece shape to the core.
REQ-011 core_position  out  3  piece column to the core.
REQ-012 core_score_valid  in  1  core has finished processing a piece.
REQ-013 core_fail  in  1  game over; qualified by core_score_valid.
REQ-014 core_score  in  4  running score; qualified by core_score_valid.
REQ-015 core_tetris_valid  in  1  final board valid; qualified by core_score_valid.
REQ-016 core_tetris  in  72  final board.
REQ-017 round_done  out  1  one-cycle pulse at round end.
REQ-018 round_fail  out  1  round ended by core_fail; held until the next round_done.
REQ-019 round_score  out  4  final score of the last round.
REQ-020 round_pieces  out  5  pieces accepted in the last round.
REQ-021 round_board  out  72  final board of the last round.
REQ-022 err  out  1  sticky timeout flag.
REQ-023 err_clr  in  1  clears err and returns the controller to ISSUE.

Function
REQ-024 FSM states SHALL be ISSUE, WAIT, DONE, ERR.
REQ-025 ISSUE: req_ready=1 (combinational from state); req_valid&req_ready SHALL register the tetromino and position, increment the piece count and move to WAIT.
REQ-026 core_in_valid SHALL be high for exactly the cycle after the handshake, with core_tetrominoes and core_position driven from registers; these outputs SHALL be 0 when core_in_valid=0.
REQ-027 At most one piece SHALL be outstanding; req_ready=0 in WAIT, DONE and ERR.
REQ-028 WAIT: a 6-bit timer SHALL clear on entry and increment each cycle while core_score_valid=0.
REQ-029 On core_score_valid with core_fail=1, or with piece count = PIECES_PER_ROUND, the FSM SHALL capture core_score, core_fail, the piece count and core_tetris (0 if core_tetris_valid=0) into the round_* registers, then enter DONE.
REQ-030 On core_score_valid with neither condition true, the FSM SHALL return to ISSUE.
REQ-031 core_fail SHALL take priority over the piece-count condition; both true SHALL give round_fail=1.
REQ-032 If the timer reaches TIMEOUT with no core_score_valid, the FSM SHALL enter ERR and set err=1.
REQ-033 DONE SHALL last one cycle: round_done=1, the piece count clears to 0, next state ISSUE.
REQ-034 ERR SHALL hold until err_clr=1; err_clr SHALL clear err and the piece count and move to ISSUE; err_clr SHALL be ignored in other states.
REQ-035 core_score_valid outside WAIT SHALL be ignored.
REQ-036 The piece count SHALL be 5 bits and never exceed PIECES_PER_ROUND.

Reset
REQ-037 On rst=1, from any state, mid-round included: state=ISSUE; piece count and timer=0; core_in_valid, round_done, round_fail, err=0; round_score=0, round_pieces=0, round_board=0; core_tetrominoes and core_position=0.
REQ-038 The first handshake SHALL be accepted in the first clk edge after rst deasserts.

Verification
REQ-039 Issue 16 pieces, core answers each after 3 cycles, fail=0, score=2 on the last -> one round_done, round_pieces=16, round_score=2, round_fail=0, round_board=core_tetris.
REQ-040 Core answers piece 5 with fail=1 -> round_done the cycle after, round_pieces=5, round_fail=1; next handshake starts a new round at count 1.
REQ-041 Core never answers -> err=1 at cycle TIMEOUT after entry to WAIT, req_ready=0; err_clr pulse -> err=0, req_ready=1.
REQ-042 Hold req_valid=1 continuously with core latency 1 -> exactly one core_in_valid per core_score_valid, never two pieces outstanding.
REQ-043 Assert rst during WAIT on piece 9 -> all outputs reach reset values immediately; the next round counts from 1.
REQ-044 Piece 16 answered with fail=1 -> round_fail=1, round_pieces=16.
